// File: rtl/fp_matrix_loader.sv
// Loads a dim x dim matrix of 32-bit words from Avalon memory into a local RAM.
// A custom instruction starts the load, and an Avalon-slave read acknowledges completion.
module fp_matrix_loader #(
  parameter int ADDR_WIDTH      = 24,
  parameter int MAX_DIM         = 32,
  parameter int RAM_AW          = 10,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ci_start,
  input  logic [31:0]           ci_dataa,
  input  logic [31:0]           ci_datab,
  output logic                  ci_done,
  output logic [31:0]           ci_result,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [RAM_AW-1:0]     ram_wraddr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_wren,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic                  irq
);

  // state | meaning
  // IDLE  | waiting for a load command
  // LOAD  | issuing reads and writing returned words into the RAM
  // DRAIN | aborted; discarding reads that are still in flight
  // DONE  | matrix loaded, irq raised until the slave read acknowledges it
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int              OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   MAX_OUT_C = OW'(MAX_OUTSTANDING);
  localparam logic [7:0]      MAX_DIM_C = 8'(MAX_DIM);
  localparam logic [31:0]     CMD_ABORT = 32'hFFFF_FFFF;
  localparam logic [31:0]     RES_READY = 32'd0;
  localparam logic [31:0]     RES_BUSY  = 32'd1;
  localparam logic [31:0]     RES_DONE  = 32'd3;
  localparam logic [31:0]     RES_DIM   = 32'd5;
  localparam logic [31:0]     RES_ABORT = 32'd6;
  localparam logic [31:0]     RES_START = 32'd99;

  state_t                state, state_next;
  logic [7:0]            dim_q;
  logic [7:0]            col;
  logic [ADDR_WIDTH-1:0] stride;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [15:0]           total;
  logic [15:0]           issued;
  logic [15:0]           issued_next;
  logic [15:0]           load_idx;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         out_next;

  logic [7:0]            cmd_dim;
  logic [15:0]           cmd_stride;
  logic [15:0]           eff_stride;
  logic                  cmd_abort;
  logic                  dim_ok;
  logic                  accept;
  logic                  rsp;
  logic                  load_done;
  logic                  read_next;

  logic                  start_ok;
  logic                  abort;
  logic [31:0]           ci_code;

  logic                  unused_dataa;
  assign unused_dataa = ^ci_dataa[31:ADDR_WIDTH];

  assign cmd_dim    = ci_datab[7:0];
  assign cmd_stride = ci_datab[23:8];
  assign cmd_abort  = (ci_datab == CMD_ABORT);
  assign dim_ok     = (cmd_dim >= 8'd2) && (cmd_dim <= MAX_DIM_C);
  // A zero stride means rows are packed back to back.
  assign eff_stride = (cmd_stride == 16'd0) ? {6'd0, cmd_dim, 2'b00} : cmd_stride;

  assign accept      = avm_read & ~avm_waitrequest;
  assign rsp         = avm_readdatavalid & (outstanding != '0) &
                       ((state == LOAD) | (state == DRAIN));
  assign out_next    = outstanding + OW'(accept) - OW'(rsp);
  assign issued_next = issued + 16'(accept);
  assign load_done   = ram_wren && (load_idx == total);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok)          state_next = LOAD;
      LOAD:    if (abort)             state_next = DRAIN;
               else if (load_done)    state_next = DONE;
      DRAIN:   if (outstanding == '0) state_next = IDLE;
      DONE:    if (avs_read)          state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    ci_code  = RES_READY;
    start_ok = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_abort || cmd_dim < 8'd2) ci_code = RES_READY;
        else if (!dim_ok)                ci_code = RES_DIM;
        else begin
          ci_code  = RES_START;
          start_ok = ci_start;
        end
      end
      LOAD: begin
        ci_code = cmd_abort ? RES_ABORT : RES_BUSY;
        abort   = ci_start & cmd_abort;
      end
      DRAIN:   ci_code = RES_BUSY;
      DONE:    ci_code = RES_DONE;
      default: ci_code = RES_READY;
    endcase
  end

  // A stalled request is held untouched; otherwise issue while reads remain and credit allows.
  always_comb begin
    read_next = 1'b0;
    if (state == LOAD && !abort) begin
      if (avm_read && avm_waitrequest) read_next = 1'b1;
      else read_next = (issued_next < total) && (out_next < MAX_OUT_C);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ci_done      <= 1'b0;
      ci_result    <= '0;
      avm_address  <= '0;
      avm_read     <= 1'b0;
      ram_wraddr   <= '0;
      ram_wdata    <= '0;
      ram_wren     <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
      dim_q        <= '0;
      col          <= '0;
      stride       <= '0;
      row_base     <= '0;
      total        <= '0;
      issued       <= '0;
      load_idx     <= '0;
      outstanding  <= '0;
    end else begin
      ci_done   <= ci_start;
      ci_result <= ci_start ? ci_code : '0;
      avm_read  <= read_next;
      ram_wren  <= 1'b0;

      if (start_ok) begin
        dim_q       <= cmd_dim;
        stride      <= ADDR_WIDTH'(eff_stride);
        total       <= 16'(cmd_dim) * 16'(cmd_dim);
        row_base    <= ci_dataa[ADDR_WIDTH-1:0];
        avm_address <= ci_dataa[ADDR_WIDTH-1:0];
        col         <= '0;
        issued      <= '0;
        load_idx    <= '0;
        outstanding <= '0;
      end else begin
        outstanding <= out_next;
        if (accept) begin
          issued <= issued_next;
          if (col == dim_q - 8'd1) begin
            col         <= '0;
            row_base    <= row_base + stride;
            avm_address <= row_base + stride;
          end else begin
            col         <= col + 8'd1;
            avm_address <= avm_address + ADDR_WIDTH'(4);
          end
        end
        if (rsp && state == LOAD) begin
          ram_wren   <= 1'b1;
          ram_wdata  <= avm_readdata;
          ram_wraddr <= load_idx[RAM_AW-1:0];
          load_idx   <= load_idx + 16'd1;
        end
      end

      if (state == LOAD && state_next == DONE) begin
        irq          <= 1'b1;
        avs_readdata <= {16'h0, load_idx};
      end else if (state == DONE && avs_read) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_matrix_loader.sv
// Directed bench for fp_matrix_loader with a behavioural Avalon read slave
// whose stalls and response timing each scenario task can steer.
module tb_fp_matrix_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic        ci_done;
  logic [31:0] ci_result;
  logic [23:0] avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [9:0]  ram_wraddr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        irq;

  always #5 clk = ~clk;

  fp_matrix_loader dut (
    .clk(clk), .reset_n(reset_n),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_done(ci_done), .ci_result(ci_result),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .ram_wraddr(ram_wraddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          hold = 1'b0;
  int          credits = 0;
  bit          stray = 1'b0;
  bit          toggle = 1'b0;
  int          accept_limit = 1 << 30;
  int          acc_count = 0;
  int          tb_out = 0;
  int          max_out = 0;
  bit          chk_hold = 1'b0;
  int          hold_viol = 0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_addr = '0;
  int          cyc = 0;
  logic [23:0] pend[$];
  logic [23:0] acc_log[$];
  logic [9:0]  wa_log[$];
  logic [31:0] wd_log[$];

  // Slave model: everything is decided on the falling edge for the next rising edge.
  always @(negedge clk) begin
    logic [23:0] a;
    cyc++;
    if (stray) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
      stray             = 1'b0;
    end else if (pend.size() > 0 && (!hold || credits > 0)) begin
      a = pend.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = {8'h5A, a};
      if (hold) credits--;
      tb_out--;
    end else begin
      avm_readdatavalid = 1'b0;
    end
    avm_waitrequest = toggle ? cyc[0] : (acc_count >= accept_limit);
    if (chk_hold && prev_stall && (!avm_read || avm_address != prev_addr)) hold_viol++;
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    if (avm_read && !avm_waitrequest) begin
      pend.push_back(avm_address);
      acc_log.push_back(avm_address);
      acc_count++;
      tb_out++;
      if (tb_out > max_out) max_out = tb_out;
    end
    if (ram_wren) begin
      wa_log.push_back(ram_wraddr);
      wd_log.push_back(ram_wdata);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    wa_log.delete();
    wd_log.delete();
    max_out = 0;
  endtask

  task automatic do_ci(input logic [31:0] a, input logic [31:0] b,
                       output logic done, output logic [31:0] res);
    @(negedge clk);
    ci_dataa = a;
    ci_datab = b;
    ci_start = 1'b1;
    @(negedge clk);
    ci_start = 1'b0;
    done = ci_done;
    res  = ci_result;
  endtask

  task automatic avs_ack();
    @(negedge clk);
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic wait_irq(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (irq) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ci_start = 1'b0; ci_dataa = '0; ci_datab = '0; avs_read = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(1);
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL reset_avm_read: got %b expected 0", avm_read); end
    n_checks++; if (avm_address !== 24'h0) begin n_fail++; $display("FAIL reset_avm_address: got %0h expected 0", avm_address); end
    n_checks++; if (ci_done !== 1'b0 || ci_result !== 32'h0) begin n_fail++; $display("FAIL reset_ci: got done %b result %0d expected 0/0", ci_done, ci_result); end
    n_checks++; if (ram_wren !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_wren_irq: got %b/%b expected 0/0", ram_wren, irq); end
    n_checks++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_avs_readdata: got %0h expected 0", avs_readdata); end
  endtask

  task automatic test_packed();
    logic d; logic [31:0] r; bit ok; logic [23:0] ea;
    clear_logs();
    do_ci(32'h1000, 32'd4, d, r);
    n_checks++; if (d !== 1'b1 || r !== 32'd99) begin n_fail++; $display("FAIL packed_start: got done %b result %0d expected 1/99", d, r); end
    @(negedge clk);
    n_checks++; if (ci_done !== 1'b0 || ci_result !== 32'd0) begin n_fail++; $display("FAIL packed_done_pulse: got done %b result %0d expected 0/0", ci_done, ci_result); end
    wait_irq(300, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL packed_irq: got %b expected 1", ok); end
    n_checks++; if (acc_log.size() != 16 || wa_log.size() != 16) begin n_fail++; $display("FAIL packed_counts: got %0d reads %0d writes expected 16/16", acc_log.size(), wa_log.size()); end
    for (int i = 0; i < 16; i++) begin
      ea = 24'h1000 + 24'(i * 4);
      if (i < acc_log.size()) begin
        n_checks++; if (acc_log[i] !== ea) begin n_fail++; $display("FAIL packed_addr[%0d]: got %0h expected %0h", i, acc_log[i], ea); end
      end
      if (i < wa_log.size()) begin
        n_checks++; if (wa_log[i] !== 10'(i) || wd_log[i] !== {8'h5A, ea}) begin n_fail++; $display("FAIL packed_write[%0d]: got %0d/%0h expected %0d/%0h", i, wa_log[i], wd_log[i], i, {8'h5A, ea}); end
      end
    end
    avs_ack();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL packed_irq_clear: got %b expected 0", irq); end
    n_checks++; if (avs_readdata !== 32'd16) begin n_fail++; $display("FAIL packed_avs_readdata: got %0d expected 16", avs_readdata); end
    do_ci(32'h0, 32'd1, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL packed_back_idle: got %0d expected 0", r); end
    wait_cycles(2);
    n_checks++; if (avs_readdata !== 32'd16) begin n_fail++; $display("FAIL packed_avs_hold: got %0d expected 16", avs_readdata); end
  endtask

  task automatic test_strided();
    logic d; logic [31:0] r; bit ok;
    logic [23:0] exp_a [9];
    exp_a = '{24'd0, 24'd4, 24'd8, 24'd64, 24'd68, 24'd72, 24'd128, 24'd132, 24'd136};
    clear_logs();
    hold_viol = 0; toggle = 1'b1; chk_hold = 1'b1;
    do_ci(32'h0, 32'h0000_4003, d, r);
    n_checks++; if (r !== 32'd99) begin n_fail++; $display("FAIL strided_start: got %0d expected 99", r); end
    wait_irq(300, ok);
    toggle = 1'b0; chk_hold = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL strided_irq: got %b expected 1", ok); end
    n_checks++; if (acc_log.size() != 9 || wa_log.size() != 9) begin n_fail++; $display("FAIL strided_counts: got %0d reads %0d writes expected 9/9", acc_log.size(), wa_log.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < acc_log.size()) begin
        n_checks++; if (acc_log[i] !== exp_a[i]) begin n_fail++; $display("FAIL strided_addr[%0d]: got %0h expected %0h", i, acc_log[i], exp_a[i]); end
      end
      if (i < wa_log.size()) begin
        n_checks++; if (wa_log[i] !== 10'(i) || wd_log[i] !== {8'h5A, exp_a[i]}) begin n_fail++; $display("FAIL strided_write[%0d]: got %0d/%0h expected %0d/%0h", i, wa_log[i], wd_log[i], i, {8'h5A, exp_a[i]}); end
      end
    end
    n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL strided_stall_hold: got %0d violations expected 0", hold_viol); end
    avs_ack();
    n_checks++; if (avs_readdata !== 32'd9 || irq !== 1'b0) begin n_fail++; $display("FAIL strided_ack: got %0d irq %b expected 9/0", avs_readdata, irq); end
  endtask

  task automatic test_outstanding();
    logic d; logic [31:0] r; bit ok; int base;
    clear_logs();
    hold = 1'b1; credits = 0; base = acc_count;
    do_ci(32'h2000, 32'd4, d, r);
    n_checks++; if (r !== 32'd99) begin n_fail++; $display("FAIL outst_start: got %0d expected 99", r); end
    wait_cycles(30);
    n_checks++; if (acc_count - base != 8) begin n_fail++; $display("FAIL outst_cap: got %0d accepts expected 8", acc_count - base); end
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL outst_read_low: got %b expected 0", avm_read); end
    credits = 1;
    wait_cycles(8);
    n_checks++; if (acc_count - base != 9) begin n_fail++; $display("FAIL outst_release: got %0d accepts expected 9", acc_count - base); end
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL outst_read_low2: got %b expected 0", avm_read); end
    hold = 1'b0;
    wait_irq(300, ok);
    n_checks++; if (ok !== 1'b1 || wa_log.size() != 16) begin n_fail++; $display("FAIL outst_finish: got irq %b writes %0d expected 1/16", ok, wa_log.size()); end
    n_checks++; if (max_out != 8) begin n_fail++; $display("FAIL outst_max: got %0d expected 8", max_out); end
    do_ci(32'h0, 32'd4, d, r);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL outst_start_in_done: got %0d expected 3", r); end
    avs_ack();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL outst_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_errors();
    logic d; logic [31:0] r; bit ok;
    do_ci(32'h0, 32'd33, d, r);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL err_dim33: got %0d expected 5", r); end
    do_ci(32'h0, 32'd1, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL err_dim1: got %0d expected 0", r); end
    do_ci(32'h0, 32'd0, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL err_dim0: got %0d expected 0", r); end
    do_ci(32'h0, 32'hFFFF_FFFF, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL err_idle_abort: got %0d expected 0", r); end
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL err_no_load: got %b expected 0", avm_read); end
    clear_logs();
    hold = 1'b1; credits = 0;
    do_ci(32'h3000, 32'd2, d, r);
    n_checks++; if (r !== 32'd99) begin n_fail++; $display("FAIL err_start2: got %0d expected 99", r); end
    wait_cycles(10);
    do_ci(32'h0, 32'd5, d, r);
    n_checks++; if (d !== 1'b1 || r !== 32'd1) begin n_fail++; $display("FAIL err_busy: got done %b result %0d expected 1/1", d, r); end
    hold = 1'b0;
    wait_irq(200, ok);
    n_checks++; if (ok !== 1'b1 || wa_log.size() != 4) begin n_fail++; $display("FAIL err_load_continues: got irq %b writes %0d expected 1/4", ok, wa_log.size()); end
    avs_ack();
  endtask

  task automatic test_abort();
    logic d; logic [31:0] r; int base; int nw;
    clear_logs();
    base = acc_count;
    accept_limit = acc_count + 5; hold = 1'b1; credits = 2;
    do_ci(32'h4000, 32'd4, d, r);
    n_checks++; if (r !== 32'd99) begin n_fail++; $display("FAIL abort_start: got %0d expected 99", r); end
    for (int i = 0; i < 50; i++) begin
      if (acc_count - base == 5 && wa_log.size() == 2) break;
      wait_cycles(1);
    end
    wait_cycles(3);
    n_checks++; if (acc_count - base != 5 || tb_out != 3) begin n_fail++; $display("FAIL abort_setup: got %0d accepts %0d outstanding expected 5/3", acc_count - base, tb_out); end
    do_ci(32'h0, 32'hFFFF_FFFF, d, r);
    n_checks++; if (r !== 32'd6) begin n_fail++; $display("FAIL abort_result: got %0d expected 6", r); end
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL abort_read_low: got %b expected 0", avm_read); end
    #1;
    nw = wa_log.size();
    hold = 1'b0;
    wait_cycles(12);
    n_checks++; if (wa_log.size() != nw || tb_out != 0) begin n_fail++; $display("FAIL abort_discard: got %0d writes %0d pending expected %0d/0", wa_log.size(), tb_out, nw); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL abort_irq: got %b expected 0", irq); end
    accept_limit = 1 << 30;
    do_ci(32'h0, 32'd1, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL abort_idle: got %0d expected 0", r); end
  endtask

  task automatic test_reset_mid_load();
    logic d; logic [31:0] r; int base; int nw;
    clear_logs();
    hold = 1'b1; credits = 0; base = acc_count;
    do_ci(32'h5000, 32'd4, d, r);
    for (int i = 0; i < 20; i++) begin
      if (acc_count - base >= 3) break;
      wait_cycles(1);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (avm_read !== 1'b0 || avm_address !== 24'h0) begin n_fail++; $display("FAIL rst_mid_avm: got %b/%0h expected 0/0", avm_read, avm_address); end
    n_checks++; if (ram_wren !== 1'b0 || ram_wraddr !== 10'h0 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ram: got %b/%0h/%0h expected 0/0/0", ram_wren, ram_wraddr, ram_wdata); end
    n_checks++; if (avs_readdata !== 32'h0 || irq !== 1'b0 || ci_done !== 1'b0 || ci_result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_misc: got %0h/%b/%b/%0h expected 0/0/0/0", avs_readdata, irq, ci_done, ci_result); end
    pend.delete();
    tb_out = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(2);
    nw = wa_log.size();
    stray = 1'b1;
    wait_cycles(5);
    n_checks++; if (wa_log.size() != nw) begin n_fail++; $display("FAIL rst_mid_stray: got %0d writes expected %0d", wa_log.size(), nw); end
    hold = 1'b0;
    do_ci(32'h0, 32'd1, d, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_mid_idle: got %0d expected 0", r); end
  endtask

  initial begin
    test_reset();
    test_packed();
    test_strided();
    test_outstanding();
    test_errors();
    test_abort();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_matrix_loader.md
FP_MATRIX_LOADER -- requirements
Module: fp_matrix_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 24, meaning Avalon master byte-address width.
REQ-002 The block SHALL have parameter MAX_DIM, default 32, meaning the largest accepted square-matrix dimension.
REQ-003 The block SHALL have parameter RAM_AW, default 10, meaning local RAM word-address width (2^RAM_AW >= MAX_DIM*MAX_DIM).
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 8, meaning the pipelined-read cap.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, all logic on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- ci_start, in, 1: custom-instruction strobe.
- ci_dataa, in, 32: base byte address in [ADDR_WIDTH-1:0].
- ci_datab, in, 32: [7:0] dim, [23:8] row stride in bytes (0 = packed, dim*4).
- ci_done, out, 1: custom-instruction done.
- ci_result, out, 32: status code.
- avm_address, out, ADDR_WIDTH: read address.
- avm_read, out, 1: read request.
- avm_readdata, in, 32: read data.
- avm_readdatavalid, in, 1: read data valid.
- avm_waitrequest, in, 1: master stall.
- ram_wraddr, out, RAM_AW: RAM write address.
- ram_wdata, out, 32: RAM write data.
- ram_wren, out, 1: RAM write enable.
- avs_read, in, 1: slave read; acknowledges completion.
- avs_readdata, out, 32: completion word.
- irq, out, 1: completion interrupt, level.

Function
REQ-006 The state machine SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-007 Every ci_start SHALL produce ci_done=1 for exactly one cycle, registered one cycle after ci_start, with ci_result valid in that cycle and 0 otherwise.
REQ-008 In IDLE, ci_start with dim in 2..MAX_DIM SHALL return 99, latch base, dim and effective stride, clear counters, and enter LOAD.
REQ-009 In IDLE, ci_start with dim 0 or 1 SHALL return 0 (ready query) with no state change.
REQ-010 In IDLE, ci_start with dim > MAX_DIM SHALL return 5 with no state change.
REQ-011 In IDLE, ci_datab = 32'hFFFFFFFF SHALL return 0 with no state change.
REQ-012 In LOAD, ci_start with ci_datab = 32'hFFFFFFFF (abort) SHALL return 6, deassert avm_read on the next cycle, and enter DRAIN.
REQ-013 Any other ci_start SHALL return 1 in LOAD/DRAIN and 3 in DONE, with no state change.
REQ-014 Element (r,c) SHALL be read from base + r*stride + c*4, row-major, r,c in 0..dim-1, with address arithmetic modulo 2^ADDR_WIDTH.
REQ-015 A request SHALL be accepted when avm_read=1 and avm_waitrequest=0.
REQ-016 avm_address and avm_read SHALL hold stable while avm_waitrequest=1.
REQ-017 The outstanding counter SHALL increment on accept and decrement on avm_readdatavalid; simultaneous events SHALL leave it unchanged.
REQ-018 avm_read SHALL NOT be asserted while outstanding == MAX_OUTSTANDING or after dim*dim accepts.
REQ-019 Each avm_readdatavalid in LOAD SHALL produce, on the next cycle, ram_wren=1, ram_wdata=avm_readdata and ram_wraddr=load index (packed r*dim+c); the load index SHALL then increment.
REQ-020 After the dim*dim-th write, the block SHALL enter DONE, set irq=1, and set avs_readdata = {16'h0, words written}.
REQ-021 In DRAIN, returning data SHALL be discarded (ram_wren=0); when outstanding reaches 0 the block SHALL enter IDLE without raising irq.
REQ-022 In DONE, avs_read SHALL clear irq on the next cycle and return to IDLE; avs_readdata SHALL hold its value until the next completion.
REQ-023 avm_readdatavalid in IDLE or DONE SHALL be ignored.

Reset
REQ-024 reset_n=0 SHALL asynchronously force IDLE and clear all outputs, counters and latched registers to 0.
REQ-025 A reset during LOAD or DRAIN SHALL abandon in-flight reads; data arriving after release SHALL be ignored per REQ-023.

Verification
REQ-026 dataa=0x1000, datab=4, zero-wait slave -> ci_result=99; 16 reads at 0x1000..0x103C; RAM 0..15 written; irq=1; avs_read -> avs_readdata=16, irq=0.
REQ-027 datab=0x0000_4003 (dim 3, stride 64), base 0 -> reads at 0,4,8,64,68,72,128,132,136; RAM 0..8.
REQ-028 Slave withholds readdatavalid -> exactly 8 accepts then avm_read low; each valid releases one more request; outstanding never exceeds 8.
REQ-029 datab=33 -> ci_result=5; datab=1 -> ci_result=0; start during LOAD -> ci_result=1, load continues.
REQ-030 Abort after 5 accepts with 3 outstanding -> ci_result=6; 3 valids discarded, no ram_wren, irq=0, then IDLE; next datab=1 -> ci_result=0.
REQ-031 reset_n pulsed low mid-LOAD -> all outputs 0 immediately; a stray valid after release -> no RAM write.
